fcb_load_sequencer: RTL

Autonomous loader that sequences the FPGA Configuration Block (FCB) through its Wishbone slave port. It fetches bitstream words from system memory over a req/ack read port and programs length and checksum. It pushes words one at a time, gated by the FCB status register. It optionally runs the readback/Adler-32 verify pass and reports done/error to the SoC, replacing CPU-driven programming loops.

---
 rtl/fcb_load_sequencer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fcb_load_sequencer.sv
// fcb_load_sequencer: walks the FCB through length/checksum/control setup,
// streams bitstream words fetched from memory into the data register, gates
// each word on the status register, optionally runs the readback pass, and
// reports completion with an error code.
module fcb_load_sequencer #(
    parameter int AW       = 32,
    parameter int TIMEOUT  = 4096,
    parameter int POLL_GAP = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [31:0]   bit_len,
    input  logic [31:0]   exp_checksum,
    input  logic          verify,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          m_cyc,
    output logic          m_stb,
    output logic          m_we,
    output logic [2:0]    m_adr,
    output logic [3:0]    m_sel,
    output logic [31:0]   m_dat_o,
    input  logic [31:0]   m_dat_i,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code
);

    // A zero gap would let a status read follow a write back-to-back.
    localparam int GAP = (POLL_GAP < 1) ? 1 : POLL_GAP;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP + 1);

    typedef enum logic [3:0] {
        IDLE, WR_LEN, WR_CHK, WR_CTL, FETCH, PUSH,
        POLL, VERIFY_OR_END, RB_POLL, CLOSE, FIN
    } state_t;

    state_t          state_q, state_d;
    logic            ph_q, ph_d;
    logic [GW-1:0]   pcnt_q, pcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [27:0]     idx_q, idx_d;
    logic [27:0]     nw_q, nw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [31:0]     len_q, chk_q, word_q;
    logic            vfy_q;

    logic            acc_en, acc_we;
    logic [2:0]      acc_adr;
    logic [31:0]     acc_dat;
    logic            poll_rd, poll_to;
    logic            unused_ok;

    assign unused_ok = ^m_dat_i[31:4];

    // Timeout counter saturates at TIMEOUT instead of wrapping.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TW'(TIMEOUT)) ? v : v + TW'(1);
    endfunction

    // ceil(bits/32) with a carry bit so lengths near 2^32 do not wrap.
    function automatic logic [27:0] word_count(input logic [31:0] bits);
        logic [32:0] s;
        s = {1'b0, bits} + 33'd31;
        return s[32:5];
    endfunction

    // Control state: FSM, counters, address pointer and error code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ph_q       <= 1'b0;
            pcnt_q     <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            nw_q       <= '0;
            addr_q     <= '0;
            err_q      <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            pcnt_q     <= pcnt_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            nw_q       <= nw_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Command operands and the fetched word; only read while their state is valid.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            len_q <= bit_len;
            chk_q <= exp_checksum;
            vfy_q <= verify;
        end
        if (state_q == FETCH && mem_ack) begin
            word_q <= mem_rdata;
        end
    end

    // Next-state and bus outputs; every write state spends one idle cycle
    // before its access so FCB accesses are never back-to-back.
    always_comb begin
        state_d    = state_q;
        ph_d       = 1'b0;
        pcnt_d     = '0;
        tmo_d      = '0;
        idx_d      = idx_q;
        nw_d       = nw_q;
        addr_d     = addr_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = 3'd0;
        acc_dat    = 32'd0;
        poll_rd    = 1'b0;
        poll_to    = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        m_cyc      = 1'b0;
        m_stb      = 1'b0;
        m_we       = 1'b0;
        m_adr      = 3'd0;
        m_sel      = 4'h0;
        m_dat_o    = 32'd0;

        if (state_q == POLL || state_q == RB_POLL) begin
            tmo_d   = sat_inc(tmo_q);
            poll_to = (tmo_q == TW'(TIMEOUT));
            poll_rd = !poll_to && (pcnt_q == GW'(GAP));
            if (poll_rd) begin
                pcnt_d  = GW'(GAP - 1);
                acc_en  = 1'b1;
                acc_adr = 3'd4;
            end else begin
                pcnt_d = (pcnt_q == GW'(GAP)) ? pcnt_q : pcnt_q + GW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    idx_d  = '0;
                    nw_d   = word_count(bit_len);
                    err_d  = 2'd0;
                    if (bit_len == 32'd0) begin
                        err_d   = 2'd3;
                        state_d = FIN;
                    end else begin
                        state_d = WR_LEN;
                    end
                end
            end
            WR_LEN: begin
                if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd2; acc_dat = len_q;
                    state_d = WR_CHK;
                end
            end
            WR_CHK: begin
                if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd3; acc_dat = chk_q;
                    state_d = WR_CTL;
                end
            end
            WR_CTL: begin
                if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd0; acc_dat = 32'h1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = PUSH;
            end
            PUSH: begin
                if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd1; acc_dat = word_q;
                    idx_d   = idx_q + 28'd1;
                    addr_d  = addr_q + AW'(4);
                    state_d = POLL;
                end
            end
            POLL: begin
                if (poll_to) begin
                    err_d   = 2'd1;
                    state_d = CLOSE;
                end else if (poll_rd) begin
                    if (m_dat_i[1])                      state_d = VERIFY_OR_END;
                    else if (m_dat_i[0] && idx_q < nw_q) state_d = FETCH;
                end
            end
            VERIFY_OR_END: begin
                if (!vfy_q) state_d = CLOSE;
                else if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd0; acc_dat = 32'h2;
                    state_d = RB_POLL;
                end
            end
            RB_POLL: begin
                if (poll_to) begin
                    err_d   = 2'd1;
                    state_d = CLOSE;
                end else if (poll_rd) begin
                    // nmatch wins when both flags are raised
                    if (m_dat_i[3]) begin
                        err_d   = 2'd2;
                        state_d = CLOSE;
                    end else if (m_dat_i[2]) begin
                        err_d   = 2'd0;
                        state_d = CLOSE;
                    end
                end
            end
            CLOSE: begin
                if (!ph_q) ph_d = 1'b1;
                else begin
                    acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd0; acc_dat = 32'h0;
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FIN && state_q != FIN) err_code_d = err_d;

        if (acc_en) begin
            m_cyc   = 1'b1;
            m_stb   = 1'b1;
            m_we    = acc_we;
            m_adr   = acc_adr;
            m_sel   = 4'hF;
            m_dat_o = acc_dat;
        end
    end

    assign busy     = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign err_code = err_code_q;

endmodule
